// File: rtl/exhaustive_stim_gen.sv
// Exhaustive operand sweep source: presents every {b, a} combination in binary
// order over valid/ready, spaced by HOLD cycles, then a final all-zero vector.
module exhaustive_stim_gen #(
  parameter int W    = 2,
  parameter int HOLD = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           ready,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  output logic           valid,
  output logic           last,
  output logic [2*W:0]   vec_idx,
  output logic           busy,
  output logic           done
);

  localparam int IDXW     = 2 * W + 1;
  localparam int HOLD_EFF = (HOLD < 1) ? 1 : HOLD;
  localparam int CW       = (HOLD_EFF > 2) ? $clog2(HOLD_EFF) : 1;

  localparam logic [IDXW-1:0] LAST_OP   = IDXW'((1 << (2 * W)) - 1);
  localparam logic [CW-1:0]   HOLD_LOAD = CW'((HOLD_EFF > 1) ? HOLD_EFF - 2 : 0);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_FINAL = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [IDXW-1:0] vec_idx_q, vec_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            advance;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    cnt_d     = cnt_q;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          vec_idx_d = '0;
        end
      end
      ST_DRIVE: begin
        if (ready) begin
          if (HOLD_EFF > 1) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_FINAL: begin
        if (ready) begin
          state_d   = ST_DONE;
          vec_idx_d = '0;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // The return-to-zero vector is simply index 2^(2W): its operand slices are all zero.
    if (advance) begin
      vec_idx_d = vec_idx_q + IDXW'(1);
      state_d   = (vec_idx_q == LAST_OP) ? ST_FINAL : ST_DRIVE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign a_out   = vec_idx_q[W-1:0];
  assign b_out   = vec_idx_q[2*W-1:W];
  assign vec_idx = vec_idx_q;
  assign valid   = (state_q == ST_DRIVE) || (state_q == ST_FINAL);
  assign last    = (state_q == ST_FINAL);
  assign busy    = (state_q == ST_DRIVE) || (state_q == ST_HOLD) || (state_q == ST_FINAL);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Scoreboard bench for exhaustive_stim_gen: expected vectors are queued from a
// plain-arithmetic sweep model and popped by a monitor on every transfer.
module tb_exhaustive_stim_gen;

  localparam int W      = 2;
  localparam int HOLD_T = 10;
  localparam int NVEC   = 1 << (2 * W);

  typedef struct {
    int a;
    int b;
    int idx;
    bit last;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, ready;
  logic [W-1:0]   a_out, b_out;
  logic           valid, last, busy, done;
  logic [2*W:0]   vec_idx;

  logic           start1, ready1;
  logic [W-1:0]   a1, b1;
  logic           valid1, last1, busy1, done1;
  logic [2*W:0]   idx1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   final_cyc = 0;
  int   last_xfer = 0;
  bit   spacing_on = 1'b0;
  int   xfer_cyc [0:NVEC];
  vec_t sb_q [$];

  exhaustive_stim_gen #(.W(W), .HOLD(HOLD_T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .a_out(a_out), .b_out(b_out), .valid(valid), .last(last),
    .vec_idx(vec_idx), .busy(busy), .done(done)
  );

  exhaustive_stim_gen #(.W(W), .HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1),
    .a_out(a1), .b_out(b1), .valid(valid1), .last(last1),
    .vec_idx(idx1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference sweep: a is the low digit, b the high digit, then one zero vector.
  task automatic push_sweep();
    vec_t e;
    for (int k = 0; k < NVEC; k++) begin
      e.a = k % (1 << W);
      e.b = k / (1 << W);
      e.idx = k;
      e.last = 1'b0;
      sb_q.push_back(e);
    end
    e.a = 0; e.b = 0; e.idx = NVEC; e.last = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, done, 1);
  endtask

  // Monitor: pops the scoreboard on transfers and watches handshake invariants.
  initial begin : monitor
    bit   pend;
    bit   done_prev;
    int   p_idx, p_a, p_b;
    vec_t e;
    pend = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (pend) begin
          check("stall_valid", valid, 1);
          check("stall_idx", vec_idx, p_idx);
          check("stall_a", a_out, p_a);
          check("stall_b", b_out, p_b);
        end
        if (last) check("last_implies_valid", valid, 1);
        if (valid && ready) begin
          check("xfer_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("xfer_a", a_out, e.a);
            check("xfer_b", b_out, e.b);
            check("xfer_idx", vec_idx, e.idx);
            check("xfer_last", last, e.last);
            if (spacing_on && e.idx != 0) check("xfer_spacing", cyc - last_xfer, HOLD_T);
            last_xfer = cyc;
            xfer_cyc[e.idx] = cyc;
            if (e.last) final_cyc = cyc;
          end
        end
        pend  = valid && !ready;
        p_idx = vec_idx;
        p_a   = a_out;
        p_b   = b_out;
        if (done) begin
          done_cnt++;
          check("done_after_final", cyc - final_cyc, 1);
          check("done_single_cycle", done_prev, 0);
          check("done_busy_low", busy, 0);
          check("done_valid_low", valid, 0);
          check("done_a_zero", a_out, 0);
          check("done_b_zero", b_out, 0);
        end
        done_prev = done;
      end
    end
  end

  initial begin : stim
    int  d0, n, stall;
    bit  pulsed;
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; start1 = 1'b0; ready1 = 1'b1;
    #1;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", vec_idx, 0);
    check("rst_done", done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    check("idle_last", last, 0);

    // Sweep 1: ready tied high, exact HOLD spacing.
    push_sweep();
    spacing_on = 1'b1;
    ready = 1'b1;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_valid", valid, 1);
    check("first_busy", busy, 1);
    check("first_idx", vec_idx, 0);
    wait_done(400, "sweep1");
    tick();
    check("sweep1_busy_after", busy, 0);
    check("sweep1_done_once", done_cnt - d0, 1);
    check("sweep1_sb_empty", sb_q.size(), 0);
    spacing_on = 1'b0;

    // HOLD=1 instance: valid stays high for 17 consecutive cycles.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k <= NVEC; k++) begin
      check("h1_valid", valid1, 1);
      check("h1_idx", idx1, k);
      check("h1_last", last1, k == NVEC);
      check("h1_a", a1, (k < NVEC) ? k % (1 << W) : 0);
      check("h1_b", b1, (k < NVEC) ? k / (1 << W) : 0);
      tick();
    end
    check("h1_done", done1, 1);
    check("h1_done_valid", valid1, 0);
    tick();
    check("h1_done_low", done1, 0);
    check("h1_busy_low", busy1, 0);

    // Sweep 2: random backpressure, forced 5-cycle stall at idx 6, stray start at idx 3.
    push_sweep();
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    stall = 0; pulsed = 1'b0; n = 0;
    while (!done && n < 2000) begin
      start = 1'b0;
      if (valid && vec_idx == 3 && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (valid && vec_idx == 6 && stall < 5) begin
        ready = 1'b0;
        stall++;
        check("bp_a", a_out, 2);
        check("bp_b", b_out, 1);
        check("bp_valid", valid, 1);
      end else if (vec_idx >= 6 || !busy) begin
        ready = 1'b1;
      end else begin
        ready = ($urandom_range(0, 2) != 0);
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("sweep2_done_seen", done, 1);
    check("bp_stall_len", stall, 5);
    check("bp_idx7_spacing", xfer_cyc[7] - xfer_cyc[6], HOLD_T);
    ready = 1'b1;
    tick();
    check("sweep2_done_once", done_cnt - d0, 1);
    check("sweep2_sb_empty", sb_q.size(), 0);

    // Sweep 3: asynchronous reset mid-HOLD at idx 9.
    push_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(busy && !valid && vec_idx == 9) && n < 400) begin
      tick();
      n++;
    end
    check("rst_mid_reached", vec_idx, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_a", a_out, 0);
    check("arst_b", b_out, 0);
    check("arst_idx", vec_idx, 0);
    check("arst_valid", valid, 0);
    check("arst_last", last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      check("post_rst_idle_busy", busy, 0);
      check("post_rst_idle_valid", valid, 0);
    end
    push_sweep();
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_idx0", vec_idx, 0);
    wait_done(400, "sweep3");
    tick();
    check("sweep3_done_once", done_cnt - d0, 1);
    check("sweep3_sb_empty", sb_q.size(), 0);

    // Start held high: back-to-back sweeps, new valid 2 cycles after done.
    push_sweep();
    push_sweep();
    d0 = done_cnt;
    start = 1'b1;
    wait_done(400, "held1");
    n = 0;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
    check("held_restart_gap", n, 2);
    check("held_restart_idx", vec_idx, 0);
    start = 1'b0;
    tick();
    wait_done(400, "held2");
    tick();
    check("held_done_count", done_cnt - d0, 2);
    check("held_sb_empty", sb_q.size(), 0);
    check("held_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exhaustive_stim_gen.md
Name: exhaustive_stim_gen

Overview:
- Synthesizable upstream stimulus source for the small combinational blocks in this codebase, e.g. the 2-bit AND with ports a, b, v.
- Walks every {b, a} operand combination in a fixed order, then presents a final return-to-zero vector.
- Each vector is presented over a valid/ready handshake, with a programmable hold interval between vectors.
- Lets the same sweep run in hardware or in an emulation harness instead of a fixed delay-based initial block.

Parameters:
- W, 2, operand width in bits of a_out and b_out (legal range 1..8).
- HOLD, 10, minimum clock cycles from one accepted vector to the next; a value of 0 is treated as 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- ready  in  1  consumer accepts the current vector.
- a_out  out  W  operand a.
- b_out  out  W  operand b.
- valid  out  1  a_out/b_out hold a vector to be consumed.
- last  out  1  current vector is the final return-to-zero vector.
- vec_idx  out  2W+1  index of the current vector, 0..2^(2W).
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (rst_n low, any time, including mid-sweep): state=IDLE; a_out, b_out, vec_idx, valid, last, busy, done all 0. Release takes effect on the first clk edge with rst_n high.
- States: IDLE, DRIVE, HOLD, FINAL, DONE.
- IDLE:
  - start=1 at an edge -> DRIVE with vec_idx=0, a_out=b_out=0.
  - valid=1 and busy=1 in the cycle after start is sampled.
- DRIVE:
  - valid=1; a_out=vec_idx[W-1:0]; b_out=vec_idx[2W-1:W]. a varies fastest, plain binary count.
  - A transfer occurs on an edge with valid&ready.
  - While ready=0, a_out, b_out and vec_idx stay stable.
  - On transfer: if HOLD>1 -> HOLD; else advance directly (back-to-back valid).
- HOLD:
  - valid=0; a_out/b_out keep the last accepted value.
  - Remains in HOLD for HOLD-1 cycles, then advances.
- Advance:
  - If vec_idx < 2^(2W)-1: vec_idx+1 -> DRIVE.
  - Otherwise -> FINAL with vec_idx=2^(2W), a_out=b_out=0.
- FINAL:
  - valid=1 and last=1; same handshake rules as DRIVE.
  - On transfer -> DONE; valid, last and busy go low on that edge. No hold applies after the final vector.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE. a_out=b_out=0 remain driven.
- start is ignored in DRIVE, HOLD, FINAL and DONE. start in the IDLE cycle immediately after DONE begins a new sweep.
- Transfers per sweep: 2^(2W)+1 (17 at W=2).
- With ready held high, vector spacing is exactly HOLD cycles, and the first vector appears 1 cycle after start.
- valid never drops without a transfer; a vector is never skipped or repeated.
- vec_idx is wide enough to hold 2^(2W) without wrap-around.

Test Plan:
- W=2, HOLD=10, ready tied 1, start pulsed at cycle 0:
  - (a_out,b_out) accepted in order (00,00),(01,00),(10,00),(11,00),(00,01) … (11,11),(00,00) with last=1.
  - Accepted vectors 10 cycles apart; 17 transfers; done pulses once, 1 cycle after the 17th transfer; busy low afterwards.
- HOLD=1, ready=1: valid high continuously for 17 consecutive cycles; vec_idx 0..16; then done=1 for one cycle.
- Backpressure: ready=0 for 5 cycles while vec_idx=6 is presented -> a_out=10, b_out=01, valid=1 stable throughout; vec_idx=6 accepted once on the first edge with ready=1; vec_idx=7 follows HOLD cycles later.
- start pulsed again while vec_idx=3 -> ignored; the sweep continues unchanged, with exactly one done pulse at the end.
- rst_n driven low asynchronously mid-HOLD at vec_idx=9 -> all outputs 0 immediately without a clock edge; after release, no activity until start; the next sweep begins at vec_idx=0.
- start held high continuously: sweeps repeat back-to-back, and each new sweep's first valid appears 2 cycles after the previous done pulse.
